// File: rtl/pipe_muldiv_pkg.sv
// Shared encodings for the pipelined multiply/divide unit: instruction
// opcodes, controller states and the iteration counter width.
package pipe_muldiv_pkg;

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } md_state_e;

endpackage

// File: rtl/pipe_muldiv_signfix.sv
// Combinational sign handling: operand magnitudes on entry and two's
// complement correction of the raw product or quotient/remainder on exit.
module pipe_muldiv_signfix (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  input  logic [63:0] acc_i,
  input  logic        is_div_i,
  input  logic        neg_p_i,
  input  logic        neg_r_i,
  output logic [31:0] a_mag_o,
  output logic [31:0] b_mag_o,
  output logic        a_neg_o,
  output logic        b_neg_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    a_neg_o = signed_i & a_i[31];
    b_neg_o = signed_i & b_i[31];
    a_mag_o = a_neg_o ? -a_i : a_i;
    b_mag_o = b_neg_o ? -b_i : b_i;

    prod = neg_p_i ? -acc_i : acc_i;
    quo  = neg_p_i ? -acc_i[31:0]  : acc_i[31:0];
    rem  = neg_r_i ? -acc_i[63:32] : acc_i[63:32];

    if (is_div_i) begin
      hi_o = rem;
      lo_o = quo;
    end else begin
      hi_o = prod[63:32];
      lo_o = prod[31:0];
    end
  end

endmodule

// File: rtl/pipe_muldiv_ctrl.sv
// Iterative multiply/divide controller for the EX stage: 32-step shift-add
// multiply, restoring divide, HI/LO registers and pipeline stall generation.
module pipe_muldiv_ctrl #(
  parameter int unsigned CNT_W = pipe_muldiv_pkg::CNT_W
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        EXmdStart,
  input  logic [1:0]  EXmdOp,
  input  logic        EXmdSigned,
  input  logic [31:0] EXa,
  input  logic [31:0] EXb,
  input  logic        IDreadHiLo,
  input  logic        IDmdStart,
  input  logic        abort,
  output logic        mdBusy,
  output logic        mdStall,
  output logic        mdDone,
  output logic        divZero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  import pipe_muldiv_pkg::*;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      acc_q, acc_d;
  logic [31:0]      opnd_q, opnd_d;
  logic             sgn_p_q, sgn_p_d;
  logic             sgn_r_q, sgn_r_d;
  logic             is_div_q, is_div_d;
  logic             dz_q, dz_d;
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0] a_mag, b_mag;
  logic        a_neg, b_neg;
  logic [31:0] fix_hi, fix_lo;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_t, div_diff;
  logic [63:0] div_next;

  pipe_muldiv_signfix u_signfix (
    .a_i      (EXa),
    .b_i      (EXb),
    .signed_i (EXmdSigned),
    .acc_i    (acc_q),
    .is_div_i (is_div_q),
    .neg_p_i  (sgn_p_q),
    .neg_r_i  (sgn_r_q),
    .a_mag_o  (a_mag),
    .b_mag_o  (b_mag),
    .a_neg_o  (a_neg),
    .b_neg_o  (b_neg),
    .hi_o     (fix_hi),
    .lo_o     (fix_lo)
  );

  // acc_q doubles as {partial product, multiplier} and {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    div_t    = {acc_q[63:32], acc_q[31]};
    div_diff = div_t - {1'b0, opnd_q};
    div_next = div_diff[32] ? {div_t[31:0], acc_q[30:0], 1'b0}
                            : {div_diff[31:0], acc_q[30:0], 1'b1};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    sgn_p_d    = sgn_p_q;
    sgn_r_d    = sgn_r_q;
    is_div_d   = is_div_q;
    dz_d       = dz_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (EXmdStart && !abort) begin
          unique case (md_op_e'(EXmdOp))
            OP_MULT: begin
              opnd_d   = a_mag;
              acc_d    = {32'd0, b_mag};
              sgn_p_d  = a_neg ^ b_neg;
              sgn_r_d  = a_neg;
              is_div_d = 1'b0;
              dz_d     = 1'b0;
              cnt_d    = '1;
              state_d  = ST_MUL;
            end
            OP_DIV: begin
              sgn_p_d  = a_neg ^ b_neg;
              sgn_r_d  = a_neg;
              is_div_d = 1'b1;
              if (EXb == '0) begin
                // divide by zero bypasses iteration; FIX writes acc_q unmodified
                acc_d   = {EXa, 32'hFFFF_FFFF};
                dz_d    = 1'b1;
                state_d = ST_FIX;
              end else begin
                opnd_d     = b_mag;
                acc_d      = {32'd0, a_mag};
                dz_d       = 1'b0;
                div_zero_d = 1'b0;
                cnt_d      = '1;
                state_d    = ST_DIV;
              end
            end
            OP_MTHI: hi_d = EXa;
            OP_MTLO: lo_d = EXa;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = (state_q == ST_MUL) ? mul_next : div_next;
          if (cnt_q == '0) state_d = ST_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!abort) begin
          done_d = 1'b1;
          if (dz_q) begin
            hi_d       = acc_q[63:32];
            lo_d       = acc_q[31:0];
            div_zero_d = 1'b1;
          end else begin
            hi_d = fix_hi;
            lo_d = fix_lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      sgn_p_q    <= 1'b0;
      sgn_r_q    <= 1'b0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      sgn_p_q    <= sgn_p_d;
      sgn_r_q    <= sgn_r_d;
      is_div_q   <= is_div_d;
      dz_q       <= dz_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  always_comb begin
    mdBusy  = (state_q != ST_IDLE);
    mdStall = mdBusy & (IDreadHiLo | IDmdStart);
    mdDone  = done_q;
    divZero = div_zero_q;
    hi      = hi_q;
    lo      = lo_q;
  end

endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
// Randomized bench for pipe_muldiv_ctrl against an arithmetic HI/LO model.
module tb_pipe_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        clrn;
  logic        EXmdStart;
  logic [1:0]  EXmdOp;
  logic        EXmdSigned;
  logic [31:0] EXa, EXb;
  logic        IDreadHiLo, IDmdStart, abort;
  logic        mdBusy, mdStall, mdDone, divZero;
  logic [31:0] hi, lo;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;

  pipe_muldiv_ctrl #(.CNT_W(5)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .EXmdStart  (EXmdStart),
    .EXmdOp     (EXmdOp),
    .EXmdSigned (EXmdSigned),
    .EXa        (EXa),
    .EXb        (EXb),
    .IDreadHiLo (IDreadHiLo),
    .IDmdStart  (IDmdStart),
    .abort      (abort),
    .mdBusy     (mdBusy),
    .mdStall    (mdStall),
    .mdDone     (mdDone),
    .divZero    (divZero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the architectural meaning of each op.
  function automatic int model_apply(input logic [1:0] op, input logic sgn,
                                     input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up;
    case (op)
      2'b00: begin
        if (sgn) begin
          sa = $signed(a); sb = $signed(b); sp = sa * sb;
          up = sp;
        end else begin
          up = {32'd0, a} * {32'd0, b};
        end
        m_hi = up[63:32];
        m_lo = up[31:0];
        return 33;
      end
      2'b01: begin
        if (b == 32'd0) begin
          m_hi = a; m_lo = 32'hFFFF_FFFF; m_dz = 1'b1;
          return 1;
        end
        m_dz = 1'b0;
        if (sgn) begin
          sa = $signed(a); sb = $signed(b);
          sq = sa / sb; sr = sa % sb;
          m_lo = sq[31:0]; m_hi = sr[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
        return 33;
      end
      2'b10: begin m_hi = a; return 0; end
      default: begin m_lo = a; return 0; end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b);
    int          lat;
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi; old_lo = m_lo;
    EXmdStart = 1'b1; EXmdOp = op; EXmdSigned = sgn; EXa = a; EXb = b;
    lat = model_apply(op, sgn, a, b);
    tick();
    EXmdStart = 1'b0; EXa = $urandom; EXb = $urandom;
    if (lat == 0) begin
      check("mv_hi", hi, m_hi);
      check("mv_lo", lo, m_lo);
      check("mv_busy", mdBusy, 1'b0);
      check("mv_done", mdDone, 1'b0);
      return;
    end
    for (int k = 0; k < lat; k++) begin
      check("busy", mdBusy, 1'b1);
      check("done_early", mdDone, 1'b0);
      check("hi_hold", hi, old_hi);
      check("lo_hold", lo, old_lo);
      IDreadHiLo = 1'($urandom_range(0, 1));
      IDmdStart  = 1'($urandom_range(0, 1));
      EXmdStart  = ($urandom_range(0, 3) == 0);
      EXmdOp     = 2'($urandom_range(0, 3));
      #1;
      check("stall", mdStall, IDreadHiLo | IDmdStart);
      tick();
    end
    EXmdStart = 1'b0; IDreadHiLo = 1'b1; IDmdStart = 1'b0;
    check("busy_end", mdBusy, 1'b0);
    check("done", mdDone, 1'b1);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("divzero", divZero, m_dz);
    #1;
    check("stall_idle", mdStall, 1'b0);
    IDreadHiLo = 1'b0;
    tick();
    check("done_pulse", mdDone, 1'b0);
  endtask

  task automatic run_abort(input bit use_reset);
    EXmdStart = 1'b1; EXmdOp = 2'b01; EXmdSigned = 1'b1;
    EXa = $urandom; EXb = $urandom | 32'd1;
    tick();
    EXmdStart = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    check("ab_busy9", mdBusy, 1'b1);
    if (use_reset) begin
      #2 clrn = 1'b0;
      IDreadHiLo = 1'b1;
      #1;
      m_hi = '0; m_lo = '0; m_dz = 1'b0;
      check("rst_busy", mdBusy, 1'b0);
      check("rst_stall", mdStall, 1'b0);
      check("rst_hi", hi, m_hi);
      check("rst_lo", lo, m_lo);
      check("rst_dz", divZero, m_dz);
      check("rst_done", mdDone, 1'b0);
      IDreadHiLo = 1'b0;
      tick();
      clrn = 1'b1;
    end else begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_busy", mdBusy, 1'b0);
      check("ab_hi", hi, m_hi);
      check("ab_lo", lo, m_lo);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ab_nodone", mdDone, 1'b0);
      check("ab_idle", mdBusy, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    clrn = 1'b0; EXmdStart = 1'b0; EXmdOp = '0; EXmdSigned = 1'b0;
    EXa = '0; EXb = '0; IDreadHiLo = 1'b1; IDmdStart = 1'b1; abort = 1'b0;
    #12;
    check("rst0_busy", mdBusy, 1'b0);
    check("rst0_stall", mdStall, 1'b0);
    check("rst0_done", mdDone, 1'b0);
    check("rst0_dz", divZero, 1'b0);
    check("rst0_hi", hi, 32'd0);
    check("rst0_lo", lo, 32'd0);
    IDreadHiLo = 1'b0; IDmdStart = 1'b0;
    tick();
    clrn = 1'b1;
    tick();

    run_op(2'b00, 1'b1, 32'd7, 32'hFFFF_FFFD);
    run_op(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b01, 1'b0, 32'd100, 32'd7);
    run_op(2'b01, 1'b1, 32'd5, 32'd0);
    run_op(2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 1'b0, 32'hDEAD_BEEF, 32'd0);
    run_op(2'b11, 1'b0, 32'h1234_5678, 32'd0);

    run_abort(1'b0);
    run_abort(1'b1);

    // abort and start together in IDLE: nothing begins
    EXmdStart = 1'b1; EXmdOp = 2'b00; EXa = 32'd3; EXb = 32'd4; abort = 1'b1;
    tick();
    EXmdStart = 1'b0; abort = 1'b0;
    check("ab_start_busy", mdBusy, 1'b0);
    tick();
    check("ab_start_done", mdDone, 1'b0);
    check("ab_start_hi", hi, m_hi);
    check("ab_start_lo", lo, m_lo);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, 1'($urandom_range(0, 1)), a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
